// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle for the round-robin arbiter. N lanes of request signals
// are packed side by side: lane i occupies slice i of every packed bus.
// The read data path is shared by all lanes.
//   master modport : drives cyc/stb/we/adr/dat_w/sel; receives dat_r/ack/err
//   slave  modport : receives cyc/stb/we/adr/dat_w/sel; drives dat_r/ack/err
interface wb_rr_arbiter_if #(
  parameter int unsigned N  = 1,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  logic [N-1:0]      cyc;
  logic [N-1:0]      stb;
  logic [N-1:0]      we;
  logic [N*AW-1:0]   adr;
  logic [N*DW-1:0]   dat_w;
  logic [N*SW-1:0]   sel;
  logic [DW-1:0]     dat_r;
  logic [N-1:0]      ack;
  logic [N-1:0]      err;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: shares one slave port between NUM_MASTERS
// masters. A granted master keeps the bus until it drops cyc. A watchdog
// raises err on the granted master after TIMEOUT stalled strobe cycles.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   m_bus   : master-facing bundle (N lanes); dat_r is broadcast s_bus.dat_r
//   s_bus   : slave-facing bundle (single lane)
//   grant_o : one-hot grant, all-zero while idle
module wb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  wb_rr_arbiter_if.slave         m_bus,
  wb_rr_arbiter_if.master        s_bus,
  output logic [NUM_MASTERS-1:0] grant_o
);

  localparam int unsigned N       = NUM_MASTERS;
  localparam int unsigned SW      = DATA_WIDTH / 8;
  localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1;
  // Counter only ever holds 0 .. TIMEOUT-1.
  localparam int unsigned WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  g_q, g_d;
  logic [IW-1:0]  p_q, p_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic [IW-1:0]  pick_idx;
  logic           pick_found;
  logic [IW:0]    cand;
  logic [IW:0]    g_inc;
  logic [IW-1:0]  g_next;
  logic           stall_c;
  logic           wd_fire_c;

  logic [ADDR_WIDTH-1:0] adr_a [N];
  logic [DATA_WIDTH-1:0] dat_a [N];
  logic [SW-1:0]         sel_a [N];

  // Split packed per-master buses into lanes.
  for (genvar gi = 0; gi < int'(N); gi++) begin : g_unpack
    assign adr_a[gi] = m_bus.adr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_a[gi] = m_bus.dat_w[gi*DATA_WIDTH +: DATA_WIDTH];
    assign sel_a[gi] = m_bus.sel[gi*SW +: SW];
  end

  // First requester at or after the priority pointer, wrapping modulo N.
  always_comb begin : arb_pick
    pick_found = 1'b0;
    pick_idx   = p_q;
    cand       = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = {1'b0, p_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!pick_found && m_bus.cyc[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  // Pointer value after the current owner releases: owner + 1 modulo N.
  always_comb begin : next_ptr
    g_inc  = {1'b0, g_q} + (IW+1)'(1);
    g_next = (g_inc >= (IW+1)'(N)) ? '0 : g_inc[IW-1:0];
  end

  // Watchdog qualifiers; an ack or err in the same cycle suppresses the timeout.
  always_comb begin : wd_qual
    stall_c   = (state_q == ST_BUSY) && m_bus.stb[g_q] &&
                !s_bus.ack[0] && !s_bus.err[0];
    wd_fire_c = (TIMEOUT != 0) && stall_c && (wd_q == WDW'(WD_LAST));
  end

  // State register.
  always_ff @(posedge clk_i) begin : state_reg
    if (rst_i) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      p_q     <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state logic.
  always_comb begin : next_state
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    wd_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (|m_bus.cyc) begin
          state_d = ST_BUSY;
          g_d     = pick_idx;
        end
      end
      ST_BUSY: begin
        if ((TIMEOUT != 0) && stall_c && !wd_fire_c) begin
          wd_d = wd_q + WDW'(1);
        end
        if (!m_bus.cyc[g_q]) begin
          state_d = ST_IDLE;
          p_d     = g_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: slave port muxed from owner, responses routed back to owner.
  always_comb begin : outputs
    s_bus.cyc   = '0;
    s_bus.stb   = '0;
    s_bus.we    = '0;
    s_bus.adr   = '0;
    s_bus.dat_w = '0;
    s_bus.sel   = '0;
    m_bus.ack   = '0;
    m_bus.err   = '0;
    grant_o     = '0;
    m_bus.dat_r = s_bus.dat_r;
    if (state_q == ST_BUSY) begin
      grant_o[g_q]   = 1'b1;
      s_bus.cyc[0]   = m_bus.cyc[g_q];
      s_bus.stb[0]   = m_bus.stb[g_q];
      s_bus.we[0]    = m_bus.we[g_q];
      s_bus.adr      = adr_a[g_q];
      s_bus.dat_w    = dat_a[g_q];
      s_bus.sel      = sel_a[g_q];
      m_bus.ack[g_q] = s_bus.ack[0];
      m_bus.err[g_q] = s_bus.err[0] | wd_fire_c;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] grant;

  wb_rr_arbiter_if #(.N(N), .AW(AW), .DW(DW)) m_if ();
  wb_rr_arbiter_if #(.N(1), .AW(AW), .DW(DW)) s_if ();

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .m_bus(m_if), .s_bus(s_if), .grant_o(grant)
  );

  always #5 clk = ~clk;

  // Stimulus state
  logic          rst_v;
  logic [N-1:0]  cyc_v, stb_v, we_v;
  logic [AW-1:0] adr_v [N];
  logic [DW-1:0] dat_v [N];
  logic [SW-1:0] sel_v [N];
  logic          ack_v, err_v;
  logic [DW-1:0] rdat_v;

  // Reference model: who owns the bus, where the search starts, stall run length
  bit m_busy;
  int m_owner, m_ptr, m_stall;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic          rst;
    logic [N-1:0]  cyc;
    logic [N-1:0]  stb;
    logic          ack;
    logic          err;
    logic [N-1:0]  e_grant;
    logic          e_scyc;
    logic [N-1:0]  e_ack;
    logic [N-1:0]  e_err;
    logic [AW-1:0] e_adr;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive();
    rst       = rst_v;
    m_if.cyc  = cyc_v;
    m_if.stb  = stb_v;
    m_if.we   = we_v;
    for (int i = 0; i < int'(N); i++) begin
      m_if.adr[i*AW +: AW]   = adr_v[i];
      m_if.dat_w[i*DW +: DW] = dat_v[i];
      m_if.sel[i*SW +: SW]   = sel_v[i];
    end
    s_if.ack[0] = ack_v;
    s_if.err[0] = err_v;
    s_if.dat_r  = rdat_v;
  endtask

  function automatic int rr_pick();
    for (int k = 0; k < int'(N); k++) begin
      int c;
      c = (m_ptr + k) % int'(N);
      if (cyc_v[c]) return c;
    end
    return m_ptr;
  endfunction

  task automatic check_model();
    logic [N-1:0]  e_grant, e_ack, e_err;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    bit            to;
    e_grant = '0; e_ack = '0; e_err = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_adr = '0; e_dat = '0; e_sel = '0;
    if (m_busy) begin
      e_grant[m_owner] = 1'b1;
      e_cyc = cyc_v[m_owner];
      e_stb = stb_v[m_owner];
      e_we  = we_v[m_owner];
      e_adr = adr_v[m_owner];
      e_dat = dat_v[m_owner];
      e_sel = sel_v[m_owner];
      to = stb_v[m_owner] && !ack_v && !err_v && (m_stall + 1 == int'(TO));
      e_ack[m_owner] = ack_v;
      e_err[m_owner] = err_v | to;
    end
    chk("model grant", 64'(grant), 64'(e_grant));
    chk("model s_cyc", 64'(s_if.cyc), 64'(e_cyc));
    chk("model s_stb", 64'(s_if.stb), 64'(e_stb));
    chk("model s_we",  64'(s_if.we),  64'(e_we));
    chk("model s_adr", 64'(s_if.adr), 64'(e_adr));
    chk("model s_dat", 64'(s_if.dat_w), 64'(e_dat));
    chk("model s_sel", 64'(s_if.sel), 64'(e_sel));
    chk("model m_ack", 64'(m_if.ack), 64'(e_ack));
    chk("model m_err", 64'(m_if.err), 64'(e_err));
    chk("model m_dat", 64'(m_if.dat_r), 64'(rdat_v));
  endtask

  task automatic model_update();
    if (rst_v) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_stall = 0;
    end else if (!m_busy) begin
      if (|cyc_v) begin
        m_owner = rr_pick();
        m_busy  = 1'b1;
        m_stall = 0;
      end
    end else begin
      if (stb_v[m_owner] && !ack_v && !err_v)
        m_stall = (m_stall + 1 >= int'(TO)) ? 0 : m_stall + 1;
      else
        m_stall = 0;
      if (!cyc_v[m_owner]) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % int'(N);
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic add(input logic r, input logic [N-1:0] c, input logic [N-1:0] s,
                     input logic a, input logic e, input logic [N-1:0] eg,
                     input logic esc, input logic [N-1:0] ea, input logic [N-1:0] ee,
                     input logic [AW-1:0] ead);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.ack = a; v.err = e;
    v.e_grant = eg; v.e_scyc = esc; v.e_ack = ea; v.e_err = ee; v.e_adr = ead;
    tbl.push_back(v);
  endtask

  // One cycle of a hand-written sequence with explicit grant/ack/err expectations.
  task automatic hand(input string nm, input logic [N-1:0] eg, input logic esc,
                      input logic [N-1:0] ea, input logic [N-1:0] ee);
    drive();
    sample();
    chk({nm, " grant"}, 64'(grant), 64'(eg));
    chk({nm, " s_cyc"}, 64'(s_if.cyc), 64'(esc));
    chk({nm, " ack"},   64'(m_if.ack), 64'(ea));
    chk({nm, " err"},   64'(m_if.err), 64'(ee));
    advance();
  endtask

  initial begin
    rst_v = 1'b1; cyc_v = '0; stb_v = '0; we_v = '0;
    ack_v = 1'b0; err_v = 1'b0; rdat_v = 32'h1234_5678;
    adr_v[0] = 32'h10; dat_v[0] = 32'hA5A5_A5A5; sel_v[0] = 4'hF; we_v[0] = 1'b1;
    adr_v[1] = 32'h20; dat_v[1] = 32'h0000_1111; sel_v[1] = 4'h3;
    adr_v[2] = 32'h30; dat_v[2] = 32'h2222_0000; sel_v[2] = 4'hC;
    drive();
    advance();

    //   rst  cyc     stb     ack   err  | grant  scyc  ack     err     adr
    add(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 32'h00);
    add(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 32'h00);
    add(1'b0, 3'b001, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 32'h00);
    add(1'b0, 3'b001, 3'b001, 1'b0, 1'b0, 3'b001, 1'b1, 3'b000, 3'b000, 32'h10);
    add(1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 3'b001, 1'b1, 3'b001, 3'b000, 32'h10);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000, 3'b000, 32'h10);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 32'h00);
    add(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 32'h00);
    add(1'b0, 3'b011, 3'b011, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 32'h00);
    add(1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 3'b001, 1'b1, 3'b001, 3'b000, 32'h10);
    add(1'b0, 3'b010, 3'b010, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000, 3'b000, 32'h10);
    add(1'b0, 3'b011, 3'b011, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 32'h00);
    add(1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 3'b010, 1'b1, 3'b010, 3'b000, 32'h20);
    add(1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 3'b010, 1'b1, 3'b010, 3'b000, 32'h20);
    add(1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 3'b010, 1'b1, 3'b010, 3'b000, 32'h20);
    add(1'b0, 3'b001, 3'b001, 1'b0, 1'b0, 3'b010, 1'b0, 3'b000, 3'b000, 32'h20);
    add(1'b0, 3'b001, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 32'h00);
    add(1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 3'b001, 1'b1, 3'b001, 3'b000, 32'h10);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000, 3'b000, 32'h10);
    add(1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 32'h00);
    add(1'b0, 3'b100, 3'b100, 1'b1, 1'b1, 3'b100, 1'b1, 3'b100, 3'b100, 32'h30);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b100, 1'b0, 3'b000, 3'b000, 32'h30);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 32'h00);

    foreach (tbl[r]) begin
      rst_v = tbl[r].rst; cyc_v = tbl[r].cyc; stb_v = tbl[r].stb;
      ack_v = tbl[r].ack; err_v = tbl[r].err;
      drive();
      sample();
      chk($sformatf("tbl%0d grant", r), 64'(grant), 64'(tbl[r].e_grant));
      chk($sformatf("tbl%0d s_cyc", r), 64'(s_if.cyc), 64'(tbl[r].e_scyc));
      chk($sformatf("tbl%0d ack", r), 64'(m_if.ack), 64'(tbl[r].e_ack));
      chk($sformatf("tbl%0d err", r), 64'(m_if.err), 64'(tbl[r].e_err));
      chk($sformatf("tbl%0d s_adr", r), 64'(s_if.adr), 64'(tbl[r].e_adr));
      advance();
    end

    // Watchdog: slave never answers, err on every 4th stalled cycle.
    rst_v = 1'b0; ack_v = 1'b0; err_v = 1'b0;
    cyc_v = 3'b001; stb_v = 3'b001;
    hand("wd arb", 3'b000, 1'b0, 3'b000, 3'b000);
    for (int s = 1; s <= 8; s++)
      hand($sformatf("wd stall%0d", s), 3'b001, 1'b1, 3'b000,
           (s == 4 || s == 8) ? 3'b001 : 3'b000);
    cyc_v = '0; stb_v = '0;
    hand("wd rel", 3'b001, 1'b0, 3'b000, 3'b000);
    hand("wd idle", 3'b000, 1'b0, 3'b000, 3'b000);

    // Watchdog: ack lands on the would-be timeout cycle and wins.
    cyc_v = 3'b001; stb_v = 3'b001;
    hand("wdack arb", 3'b000, 1'b0, 3'b000, 3'b000);
    for (int s = 1; s <= 8; s++) begin
      ack_v = (s == 4);
      hand($sformatf("wdack c%0d", s), 3'b001, 1'b1, (s == 4) ? 3'b001 : 3'b000,
           (s == 8) ? 3'b001 : 3'b000);
    end
    ack_v = 1'b0; cyc_v = '0; stb_v = '0;
    hand("wdack rel", 3'b001, 1'b0, 3'b000, 3'b000);
    hand("wdack idle", 3'b000, 1'b0, 3'b000, 3'b000);

    // Reset in the middle of a read from M1.
    we_v = '0; cyc_v = 3'b010; stb_v = 3'b010;
    hand("rmid arb", 3'b000, 1'b0, 3'b000, 3'b000);
    hand("rmid busy", 3'b010, 1'b1, 3'b000, 3'b000);
    rst_v = 1'b1;
    hand("rmid rst", 3'b010, 1'b1, 3'b000, 3'b000);
    rst_v = 1'b0;
    hand("rmid post", 3'b000, 1'b0, 3'b000, 3'b000);
    ack_v = 1'b1;
    hand("rmid regrant", 3'b010, 1'b1, 3'b010, 3'b000);
    ack_v = 1'b0; cyc_v = '0; stb_v = '0;
    hand("rmid rel", 3'b010, 1'b0, 3'b000, 3'b000);

    // Randomized traffic checked against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst_v = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < int'(N); i++) begin
        if ($urandom_range(0, 5) == 0) cyc_v[i] = ~cyc_v[i];
        stb_v[i] = cyc_v[i] && ($urandom_range(0, 3) != 0);
        we_v[i]  = 1'($urandom);
        adr_v[i] = $urandom;
        dat_v[i] = $urandom;
        sel_v[i] = SW'($urandom);
      end
      ack_v  = ($urandom_range(0, 2) == 0);
      err_v  = ($urandom_range(0, 15) == 0);
      rdat_v = $urandom;
      drive();
      sample();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
